// File: rtl/lsr_accum.sv
// lsr_accum: streaming (x, y) accumulator feeding the LSR solver.
// Optional LSR_ACC_SAT_EN: saturating sums plus sticky acc_ovf output.
`timescale 1ns/1ps
module lsr_accum #(
   parameter int DATA_SIZE = 7,
   parameter int WIDTH     = 16,
   parameter int ACC_W     = 40,
   parameter int CNT_W     = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_last,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic signed [WIDTH-1:0] y_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CNT_W-1:0]        n_out,
   output logic signed [ACC_W-1:0] sum_x,
   output logic signed [ACC_W-1:0] sum_y,
   output logic signed [ACC_W-1:0] sum_xy,
   output logic signed [ACC_W-1:0] sum_xx,
   output logic                    busy
`ifdef LSR_ACC_SAT_EN
   ,output logic                   acc_ovf
`endif
);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

   state_t state, state_nx;

   logic                      accept;
   logic                      close;
   logic                      clr;
   logic                      s1_v;
   logic [CNT_W-1:0]          a_cnt;
   logic signed [WIDTH-1:0]   s1_x, s1_y;
   logic signed [2*WIDTH-1:0] s1_xy, s1_xx;
   logic signed [2*WIDTH-1:0] x_w, y_w;
   logic signed [ACC_W-1:0]   x_e, y_e, xy_e, xx_e;

`ifdef LSR_ACC_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   function automatic logic ovf_acc(
      input logic signed [ACC_W-1:0] a,
      input logic signed [ACC_W-1:0] b
   );
      logic signed [ACC_W-1:0] s;
      s = a + b;
      return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
   endfunction
`endif

   function automatic logic signed [ACC_W-1:0] add_acc(
      input logic signed [ACC_W-1:0] a,
      input logic signed [ACC_W-1:0] b
   );
      logic signed [ACC_W-1:0] s;
      s = a + b;
`ifdef LSR_ACC_SAT_EN
      if (ovf_acc(a, b)) s = a[ACC_W-1] ? ACC_MIN : ACC_MAX;
`endif
      return s;
   endfunction

   assign accept = in_valid & in_ready;
   assign close  = in_last | (a_cnt == CNT_W'(DATA_SIZE - 1));
   assign clr    = (state == IDLE) & start;
   assign x_w    = (2*WIDTH)'(x_in);
   assign y_w    = (2*WIDTH)'(y_in);
   assign x_e    = ACC_W'(s1_x);
   assign y_e    = ACC_W'(s1_y);
   assign xy_e   = ACC_W'(s1_xy);
   assign xx_e   = ACC_W'(s1_xx);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nx = ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && close) state_nx = DRAIN;
         end
         // wait until the last product has landed in the sums
         DRAIN: if (!s1_v) state_nx = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_v  <= 1'b0;
         s1_x  <= '0;
         s1_y  <= '0;
         s1_xy <= '0;
         s1_xx <= '0;
         a_cnt <= '0;
      end else begin
         s1_v <= accept;
         if (accept) begin
            s1_x  <= x_in;
            s1_y  <= y_in;
            s1_xy <= x_w * y_w;
            s1_xx <= x_w * x_w;
         end
         if (clr)         a_cnt <= '0;
         else if (accept) a_cnt <= a_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n_out  <= '0;
         sum_x  <= '0;
         sum_y  <= '0;
         sum_xy <= '0;
         sum_xx <= '0;
      end else if (clr) begin
         n_out  <= '0;
         sum_x  <= '0;
         sum_y  <= '0;
         sum_xy <= '0;
         sum_xx <= '0;
      end else if (s1_v) begin
         n_out  <= n_out + CNT_W'(1);
         sum_x  <= add_acc(sum_x, x_e);
         sum_y  <= add_acc(sum_y, y_e);
         sum_xy <= add_acc(sum_xy, xy_e);
         sum_xx <= add_acc(sum_xx, xx_e);
      end
   end

`ifdef LSR_ACC_SAT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      acc_ovf <= 1'b0;
      else if (clr)  acc_ovf <= 1'b0;
      else if (s1_v) acc_ovf <= acc_ovf
                               | ovf_acc(sum_x, x_e)
                               | ovf_acc(sum_y, y_e)
                               | ovf_acc(sum_xy, xy_e)
                               | ovf_acc(sum_xx, xx_e);
   end
`endif

endmodule

// File: doc/lsr_accum.md
Name: lsr_accum

Overview:
- Streaming front-end stage directly upstream of the LSR solver.
- Accepts (x, y) sample pairs over a valid/ready handshake and accumulates N, Σx, Σy, Σxy and Σx².
- Presents the finished sums to the solver on an output valid/ready handshake.
- Replaces array-style data loading with a one-sample-per-cycle stream.

Parameters:
- DATA_SIZE, 7: maximum samples per regression batch (≥2).
- WIDTH, 16: signed sample width for x and y.
- ACC_W, 40: signed accumulator width for all four sums; must be ≥ 2*WIDTH.
- CNT_W, 8: sample counter width; must hold DATA_SIZE.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; clears accumulators and opens a batch.
- in_valid  in  1  sample present.
- in_ready  out  1  block accepts a sample this cycle.
- in_last  in  1  qualifies the sample as the final one of the batch (early termination).
- x_in  in  WIDTH  signed x sample.
- y_in  in  WIDTH  signed y sample.
- out_valid  out  1  sums valid.
- out_ready  in  1  solver consumes the sums.
- n_out  out  CNT_W  number of samples accumulated.
- sum_x, sum_y, sum_xy, sum_xx  out  ACC_W each  signed sums.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; in_ready=0, out_valid=0, busy=0; n_out and all sums=0; pipeline valid cleared. Takes effect mid-batch with no partial output.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 clears count and sums and moves to ACCUM on the next edge.
- ACCUM:
  - in_ready=1; accept = in_valid & in_ready.
  - Stage 1 registers x, y, x*y and x*x (full 2*WIDTH signed products) plus a valid bit.
  - Stage 2 adds the sign-extended stage-1 values into the accumulators and increments the count.
  - Go to DRAIN on the accepted sample where in_last=1 or the accept count reaches DATA_SIZE; in_ready drops on the following cycle.
- DRAIN:
  - in_ready=0.
  - One cycle for stage 2 to absorb the final sample, then go to DONE.
- DONE:
  - out_valid=1; all outputs held stable until out_ready=1.
  - On out_valid & out_ready, go to IDLE; out_valid falls next cycle and the sums retain their values.
- Latency: final sample accepted at edge k → out_valid high after edge k+2.
- start is ignored in ACCUM, DRAIN and DONE; it never restarts an open batch.
- in_last with in_valid=0 is ignored.
- Zero-sample batch is impossible: the batch closes only on an accepted sample.
- out_ready is ignored outside DONE.
- Arithmetic: two's complement; sums wrap modulo 2^ACC_W unless the optional feature is compiled in. Default widths cannot overflow for DATA_SIZE ≤ 255.

Optional Feature:
- Macro: LSR_ACC_SAT_EN.
- Defined:
  - Each accumulator saturates to ±(2^(ACC_W-1)) bounds (max 2^(ACC_W-1)-1, min -2^(ACC_W-1)) on overflow.
  - Adds output port acc_ovf (1 bit): sticky per batch, cleared on start and on reset, valid with out_valid.
- Undefined: wrap-around arithmetic; no acc_ovf port.

Test Plan:
- Full batch: start, then x=1..7 with y=2x+1 back-to-back, out_ready=1 → out_valid 2 cycles after the 7th accept; n=7, Σx=28, Σy=63, Σxy=308, Σx²=140; returns to IDLE.
- Signed data: x=-3..3, y=-x → n=7, Σx=0, Σy=0, Σxy=-28, Σx²=28.
- Early termination with gaps: x=1,2,3 / y=4,5,6 with in_valid idle cycles between samples and in_last on the 3rd → n=3, Σx=6, Σy=15, Σxy=32, Σx²=14; in_ready low from the cycle after the 3rd accept.
- Backpressure and ignored start: hold out_ready=0 for 5 cycles in DONE and pulse start → all outputs stable and no restart; out_ready=1 → IDLE the next cycle.
- Reset mid-batch: drive rst low asynchronously after 4 accepts → immediately out_valid=0, sums=0, IDLE; a fresh 7-sample batch then yields correct sums.
- Overflow, ACC_W=32, seven samples x=y=-32768 → with LSR_ACC_SAT_EN: sum_xy=2147483647, acc_ovf=1; without it: sum_xy=-1073741824.
